// File: rtl/fifo_defs.sv
// Shared FIFO defaults and the arbiter priority encoding. The controller and any
// dual-port RAM wrappers take their default geometry from here.
package fifo_defs;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 3;

  // Which producer wins when both request in the same cycle
  typedef enum logic {
    PRIO_REQ0 = 1'b0,
    PRIO_REQ1 = 1'b1
  } prio_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Grants are combinational so the write lands on
// the same posedge; the priority flop remembers who should win the next tie.
module rr_arbiter2
  import fifo_defs::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic enable,
  output logic gnt0,
  output logic gnt1
);

  prio_e prio_q, prio_d;

  // Grant decode: a lone requester always wins, a tie goes to the favoured side
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (enable) begin
      if (req0 && req1) begin
        if (prio_q == PRIO_REQ0) gnt0 = 1'b1;
        else                     gnt1 = 1'b1;
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end
    end
  end

  // After any grant the other requester becomes favoured; no grant keeps priority
  always_comb begin
    prio_d = prio_q;
    if (gnt0)      prio_d = PRIO_REQ1;
    else if (gnt1) prio_d = PRIO_REQ0;
  end

  // Priority register, requester 0 favoured out of reset
  always_ff @(posedge clk) begin
    if (rst) prio_q <= PRIO_REQ0;
    else     prio_q <= prio_d;
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller for an external dual-port RAM with two arbitrated producers
// and one consumer. Pointers carry an extra wrap bit so full and empty are
// distinguishable without a separate counter.
module ram_fifo_ctrl
  import fifo_defs::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  rd_err,
  output logic                  ram_write,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_read,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [PW-1:0]         count_q;
  logic                  full_q, empty_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  dout_valid_q, rd_err_q;
  logic                  wr_en, wr_acc, rd_acc;

  // Writes are blocked while full even if a read retires in the same cycle
  assign wr_en = !rst && !full_q;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req0   (req0),
    .req1   (req1),
    .enable (wr_en),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  // RAM-side strobes and next pointers; a read is only accepted when data exists
  always_comb begin
    wr_acc    = gnt0 | gnt1;
    rd_acc    = rd_en && !empty_q && !rst;
    ram_write = wr_acc;
    ram_waddr = wptr_q[ADDR_WIDTH-1:0];
    ram_wdata = '0;
    if (gnt0)      ram_wdata = wdata0;
    else if (gnt1) ram_wdata = wdata1;
    ram_read  = rd_acc;
    ram_raddr = rptr_q[ADDR_WIDTH-1:0];
    wptr_d    = wptr_q + PW'(wr_acc);
    rptr_d    = rptr_q + PW'(rd_acc);
  end

  // Pointer, status and read-data registers; status is derived from next pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      empty_q      <= 1'b1;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      rd_err_q     <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= wptr_d - rptr_d;
      empty_q      <= (wptr_d == rptr_d);
      full_q       <= (wptr_d[ADDR_WIDTH] != rptr_d[ADDR_WIDTH]) &&
                      (wptr_d[ADDR_WIDTH-1:0] == rptr_d[ADDR_WIDTH-1:0]);
      if (rd_acc) dout_q <= ram_rdata;
      dout_valid_q <= rd_acc;
      rd_err_q     <= rd_en && empty_q;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign full       = full_q;
  assign empty      = empty_q;
  assign count      = count_q;
  assign rd_err     = rd_err_q;

endmodule
